// File: rtl/hub75_pkg.sv
// Shared HUB75 constants, row-record layout and capture FSM states.
package hub75_pkg;

    localparam int HUB75_WIDTH  = 32;
    localparam int HUB75_ADDR_W = 4;
    localparam int HUB75_OE_W   = 16;

    // One captured row as handed to a consumer.
    typedef struct packed {
        logic [HUB75_ADDR_W-1:0] addr;
        logic [HUB75_WIDTH-1:0]  r0;
        logic [HUB75_WIDTH-1:0]  g0;
        logic [HUB75_WIDTH-1:0]  b0;
        logic [HUB75_WIDTH-1:0]  r1;
        logic [HUB75_WIDTH-1:0]  g1;
        logic [HUB75_WIDTH-1:0]  b1;
        logic [HUB75_OE_W-1:0]   oe_cycles;
        logic                    len_err;
    } hub75_row_t;

    typedef enum logic {
        RX_ARMING = 1'b0,
        RX_RUN    = 1'b1
    } hub75_rx_state_e;

endpackage

// File: rtl/hub75_sync_edge.sv
// N-stage synchronizer with a rising-edge pulse that is suppressed while
// arm_i is low, so a pin already high at reset release never looks like an edge.
module hub75_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    input  logic arm_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = arm_i & sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/hub75_rx_capture.sv
// HUB75 receive-side capture: synchronizes the panel bus, shifts each row
// into six words and presents it through a one-entry valid/ready buffer.
module hub75_rx_capture
    import hub75_pkg::*;
#(
    parameter int WIDTH       = HUB75_WIDTH,
    parameter int ADDR_W      = HUB75_ADDR_W,
    parameter int SYNC_STAGES = 2,
    parameter int OE_W        = HUB75_OE_W
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              R0,
    input  logic              G0,
    input  logic              B0,
    input  logic              R1,
    input  logic              G1,
    input  logic              B1,
    input  logic              PCLK,
    input  logic              LATCH,
    input  logic              OE,
    input  logic              RA,
    input  logic              RB,
    input  logic              RC,
    input  logic              RD,
    output logic              row_valid,
    input  logic              row_ready,
    output logic [ADDR_W-1:0] row_addr,
    output logic [WIDTH-1:0]  red0_o,
    output logic [WIDTH-1:0]  green0_o,
    output logic [WIDTH-1:0]  blue0_o,
    output logic [WIDTH-1:0]  red1_o,
    output logic [WIDTH-1:0]  green1_o,
    output logic [WIDTH-1:0]  blue1_o,
    output logic [OE_W-1:0]   oe_cycles,
    output logic              len_err,
    output logic              overflow
);

    localparam int                BUS_W    = 11;
    // OE idles high (inactive); everything else idles low.
    localparam logic [BUS_W-1:0]  BUS_RST  = 11'b100_0000_0000;
    localparam int                CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(WIDTH + 1);
    localparam int                ARM_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(SYNC_STAGES);

    hub75_rx_state_e state_q, state_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic             run;

    logic [BUS_W-1:0] bus_raw, bus_s;
    logic [BUS_W-1:0] bus_sync_q [SYNC_STAGES];
    logic [5:0]       bits_s;
    logic [3:0]       addr_s;
    logic             oe_s;
    logic             pclk_rise, latch_rise;

    logic [5:0][WIDTH-1:0] sh_q, sh_shift, sh_d;
    logic [CNT_W-1:0]      bit_cnt_q, cnt_shift, bit_cnt_d;
    logic [OE_W-1:0]       oe_cnt_q, oe_cnt_d;

    logic                  take, drop;
    logic                  valid_q, len_q, ovf_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [OE_W-1:0]       oe_q;
    logic [5:0][WIDTH-1:0] word_q;

    // Channel order in every 6-bit/6-word group: R0, G0, B0, R1, G1, B1.
    assign bus_raw = {OE, RD, RC, RB, RA, B1, G1, R1, B0, G0, R0};

    // Plain synchronizers for data, address and OE.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            for (int i = 0; i < SYNC_STAGES; i++) bus_sync_q[i] <= BUS_RST;
        end else begin
            bus_sync_q[0] <= bus_raw;
            for (int i = 1; i < SYNC_STAGES; i++) bus_sync_q[i] <= bus_sync_q[i-1];
        end
    end

    assign bus_s  = bus_sync_q[SYNC_STAGES-1];
    assign bits_s = bus_s[5:0];
    assign addr_s = bus_s[9:6];
    assign oe_s   = bus_s[10];
    assign run    = (state_q == RX_RUN);

    hub75_sync_edge #(.STAGES(SYNC_STAGES)) u_pclk_edge (
        .clk_i (CLK_I),
        .rst_i (RST_I),
        .d_i   (PCLK),
        .arm_i (run),
        .rise_o(pclk_rise)
    );

    hub75_sync_edge #(.STAGES(SYNC_STAGES)) u_latch_edge (
        .clk_i (CLK_I),
        .rst_i (RST_I),
        .d_i   (LATCH),
        .arm_i (run),
        .rise_o(latch_rise)
    );

    // FSM state register.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= RX_ARMING;
            arm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    // ARMING lasts SYNC_STAGES+1 cycles so the edge detectors see settled history.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        case (state_q)
            RX_ARMING: begin
                if (arm_cnt_q == ARM_LAST) state_d = RX_RUN;
                else                       arm_cnt_d = arm_cnt_q + 1'b1;
            end
            RX_RUN:  state_d = RX_RUN;
            default: state_d = RX_ARMING;
        endcase
    end

    // Shift/count/OE next state; a same-cycle PCLK bit is folded in before latching.
    always_comb begin
        sh_shift  = sh_q;
        cnt_shift = bit_cnt_q;
        if (pclk_rise) begin
            for (int c = 0; c < 6; c++) sh_shift[c] = {bits_s[c], sh_q[c][WIDTH-1:1]};
            if (bit_cnt_q != CNT_SAT) cnt_shift = bit_cnt_q + 1'b1;
        end
        oe_cnt_d = oe_cnt_q;
        if (run && !oe_s && (oe_cnt_q != '1)) oe_cnt_d = oe_cnt_q + 1'b1;
        sh_d      = sh_shift;
        bit_cnt_d = cnt_shift;
        if (latch_rise) begin
            sh_d      = '0;
            bit_cnt_d = '0;
            oe_cnt_d  = '0;
        end
    end

    // Row accumulation registers.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            sh_q      <= '0;
            bit_cnt_q <= '0;
            oe_cnt_q  <= '0;
        end else begin
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            oe_cnt_q  <= oe_cnt_d;
        end
    end

    // A latch loads the buffer if it is empty or being drained this cycle.
    assign take = latch_rise && (!valid_q || row_ready);
    assign drop = latch_rise && valid_q && !row_ready;

    // One-entry output buffer and sticky overflow flag.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            addr_q  <= '0;
            oe_q    <= '0;
            len_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (take) begin
                valid_q <= 1'b1;
                word_q  <= sh_shift;
                addr_q  <= ADDR_W'(addr_s);
                oe_q    <= oe_cnt_q;
                len_q   <= (cnt_shift != CNT_FULL);
            end else if (row_ready) begin
                valid_q <= 1'b0;
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign row_valid = valid_q;
    assign row_addr  = addr_q;
    assign red0_o    = word_q[0];
    assign green0_o  = word_q[1];
    assign blue0_o   = word_q[2];
    assign red1_o    = word_q[3];
    assign green1_o  = word_q[4];
    assign blue1_o   = word_q[5];
    assign oe_cycles = oe_q;
    assign len_err   = len_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_hub75_rx_capture.sv
// Scoreboard bench for hub75_rx_capture.
module tb_hub75_rx_capture;
    import hub75_pkg::*;

    localparam int W = HUB75_WIDTH;

    logic clk = 1'b0;
    logic RST_I;
    logic R0, G0, B0, R1, G1, B1;
    logic PCLK, LATCH, OE, RA, RB, RC, RD;
    logic row_valid, row_ready;
    logic [3:0]  row_addr;
    logic [31:0] red0_o, green0_o, blue0_o, red1_o, green1_o, blue1_o;
    logic [15:0] oe_cycles;
    logic        len_err, overflow;

    hub75_row_t exp_q [$];
    hub75_row_t mon_e;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hub75_rx_capture dut (
        .CLK_I(clk), .RST_I(RST_I),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .PCLK(PCLK), .LATCH(LATCH), .OE(OE),
        .RA(RA), .RB(RB), .RC(RC), .RD(RD),
        .row_valid(row_valid), .row_ready(row_ready), .row_addr(row_addr),
        .red0_o(red0_o), .green0_o(green0_o), .blue0_o(blue0_o),
        .red1_o(red1_o), .green1_o(green1_o), .blue1_o(blue1_o),
        .oe_cycles(oe_cycles), .len_err(len_err), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0][63:0] rand_bits();
        logic [5:0][63:0] r;
        for (int c = 0; c < 6; c++) r[c] = {$urandom, $urandom};
        return r;
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, 64'(row_valid), 64'(0));
        chk({tag, "_addr"},  64'(row_addr),  64'(0));
        chk({tag, "_r0"},    64'(red0_o),    64'(0));
        chk({tag, "_g0"},    64'(green0_o),  64'(0));
        chk({tag, "_b1"},    64'(blue1_o),   64'(0));
        chk({tag, "_oe"},    64'(oe_cycles), 64'(0));
        chk({tag, "_len"},   64'(len_err),   64'(0));
        chk({tag, "_ovf"},   64'(overflow),  64'(0));
    endtask

    // Shift nbits bits per channel (bits[c][k] is the k-th bit), then latch.
    task automatic send_row(input int nbits, input logic [5:0][63:0] bits, input logic [3:0] addr,
                            input int hp, input bit push, input logic [15:0] exp_oe, input bit chk_lat);
        hub75_row_t       e;
        logic [5:0][31:0] ew;
        {RD, RC, RB, RA} = addr;
        PCLK = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            {B1, G1, R1, B0, G0, R0} = {bits[5][k], bits[4][k], bits[3][k],
                                        bits[2][k], bits[1][k], bits[0][k]};
            cyc(hp);
            PCLK = 1'b1;
            cyc(hp);
            PCLK = 1'b0;
        end
        cyc(hp);
        ew = '0;
        for (int c = 0; c < 6; c++)
            for (int k = 0; k < nbits; k++) ew[c] = {bits[c][k], ew[c][31:1]};
        e.addr = addr;
        e.r0 = ew[0]; e.g0 = ew[1]; e.b0 = ew[2];
        e.r1 = ew[3]; e.g1 = ew[4]; e.b1 = ew[5];
        e.oe_cycles = exp_oe;
        e.len_err = (nbits != W);
        if (push) exp_q.push_back(e);
        LATCH = 1'b1;
        if (chk_lat) begin
            cyc(2);
            @(negedge clk);
            chk("latency_early", 64'(row_valid), 64'(0));
            @(posedge clk);
            @(negedge clk);
            chk("latency_valid", 64'(row_valid), 64'(1));
            cyc(1);
        end else begin
            cyc(3);
        end
        LATCH = 1'b0;
        cyc(4);
    endtask

    // Consumer side: pop and compare each accepted row.
    always @(negedge clk) begin
        if (RST_I === 1'b0 && row_valid === 1'b1 && row_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_row", 64'(1), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("row_addr", 64'(row_addr),  64'(mon_e.addr));
                chk("red0",     64'(red0_o),    64'(mon_e.r0));
                chk("green0",   64'(green0_o),  64'(mon_e.g0));
                chk("blue0",    64'(blue0_o),   64'(mon_e.b0));
                chk("red1",     64'(red1_o),    64'(mon_e.r1));
                chk("green1",   64'(green1_o),  64'(mon_e.g1));
                chk("blue1",    64'(blue1_o),   64'(mon_e.b1));
                chk("oe_cycles",64'(oe_cycles), 64'(mon_e.oe_cycles));
                chk("len_err",  64'(len_err),   64'(mon_e.len_err));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [5:0][63:0] b;
        RST_I = 1'b1;
        {R0, G0, B0, R1, G1, B1} = '0;
        {PCLK, LATCH, RA, RB, RC, RD} = '0;
        OE = 1'b1;
        row_ready = 1'b1;
        cyc(3);
        @(negedge clk);
        chk_outputs_zero("reset");
        cyc(1);
        RST_I = 1'b0;
        cyc(10);

        // Fixed pattern row, slow PCLK, latency check.
        b = '0;
        b[0] = 64'(32'hAAAAAA00);
        b[1] = 64'(32'hAAA00AAA);
        b[2] = 64'(32'hAA00AAAA);
        b[3] = 64'(32'h55555555);
        b[4] = 64'(32'h55555555);
        b[5] = 64'(32'h55555555);
        send_row(32, b, 4'd0, 25, 1'b1, 16'd0, 1'b1);

        // Sixteen back-to-back rows, addresses 1..15 then 0.
        for (int a = 1; a <= 16; a++) send_row(32, rand_bits(), 4'(a), 4, 1'b1, 16'd0, 1'b0);
        cyc(10);
        @(negedge clk);
        chk("no_overflow", 64'(overflow), 64'(0));
        cyc(1);

        // Short and long rows.
        send_row(31, rand_bits(), 4'd3, 4, 1'b1, 16'd0, 1'b0);
        send_row(33, rand_bits(), 4'd5, 4, 1'b1, 16'd0, 1'b0);

        // OE on-time counting and saturation.
        send_row(32, rand_bits(), 4'd6, 4, 1'b1, 16'd0, 1'b0);
        OE = 1'b0;
        cyc(600);
        OE = 1'b1;
        send_row(32, rand_bits(), 4'd7, 4, 1'b1, 16'd600, 1'b0);
        OE = 1'b0;
        cyc(70000);
        OE = 1'b1;
        send_row(32, rand_bits(), 4'd8, 4, 1'b1, 16'hFFFF, 1'b0);

        // Overflow: second row dropped while the first is held.
        cyc(10);
        row_ready = 1'b0;
        send_row(32, rand_bits(), 4'd9, 4, 1'b1, 16'd0, 1'b0);
        send_row(32, rand_bits(), 4'd10, 4, 1'b0, 16'd0, 1'b0);
        cyc(10);
        @(negedge clk);
        chk("ovf_set",    64'(overflow),  64'(1));
        chk("ovf_held_v", 64'(row_valid), 64'(1));
        chk("ovf_held_a", 64'(row_addr),  64'(9));
        cyc(1);
        row_ready = 1'b1;
        cyc(20);
        @(negedge clk);
        chk("ovf_dropped", 64'(row_valid), 64'(0));
        chk("ovf_sticky",  64'(overflow),  64'(1));
        cyc(1);

        // Reset mid-row with PCLK high at release.
        for (int k = 0; k < 10; k++) begin
            {B1, G1, R1, B0, G0, R0} = 6'($urandom);
            cyc(4);
            PCLK = 1'b1;
            cyc(4);
            if (k < 9) PCLK = 1'b0;
        end
        RST_I = 1'b1;
        cyc(2);
        @(negedge clk);
        chk_outputs_zero("midrst");
        cyc(1);
        RST_I = 1'b0;
        cyc(10);
        send_row(32, rand_bits(), 4'd12, 4, 1'b1, 16'd0, 1'b0);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc(1);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
